// File: rtl/module_spi_transfer_ctrl_pkg.sv
// Shared definitions for the SPI transfer engine: control-word field positions
// and the transfer FSM state type.
package spi_pkg;

    localparam int unsigned SEND_BIT   = 0;
    localparam int unsigned ALL_SS_BIT = 1;
    localparam int unsigned NTX_LSB    = 2;
    localparam int unsigned NTX_MSB    = 9;
    localparam int unsigned NRX_LSB    = 10;
    localparam int unsigned NRX_MSB    = 17;

    localparam int unsigned CTRL_ADDR  = 0;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_STORE  = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

endpackage

// File: rtl/module_spi_transfer_ctrl_shifter.sv
// 8-bit SPI mode-0 shift engine: MSB first, SCLK idle low, CLK_DIV clk_i
// cycles per SCLK half-period; done_o pulses on the cycle of the 8th falling edge.
module module_spi_shifter #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic       miso_i,
    output logic       done_o,
    output logic [7:0] rx_byte_o,
    output logic       sclk_o,
    output logic       mosi_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       edge_cnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic             sclk_q;
    logic             tick;

    assign tick      = active && (div_cnt == DIV_LAST);
    assign done_o    = tick && (edge_cnt == 4'd15);
    assign sclk_o    = sclk_q;
    assign rx_byte_o = rx_sr;
    // MSB is presented straight from the load byte so MOSI is valid during LOAD.
    assign mosi_o    = start_i ? tx_byte_i[7] : tx_sr[7];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active   <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            sclk_q   <= 1'b0;
        end else if (start_i) begin
            active   <= 1'b1;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sr    <= tx_byte_i;
            sclk_q   <= 1'b0;
        end else if (active) begin
            if (tick) begin
                div_cnt  <= '0;
                sclk_q   <= ~sclk_q;
                edge_cnt <= edge_cnt + 4'd1;
                if (!sclk_q) begin
                    rx_sr <= {rx_sr[6:0], miso_i};
                end else begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                end
                if (edge_cnt == 4'd15) begin
                    active <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/module_spi_transfer_ctrl.sv
// SPI transfer engine on the register bank's interface-side port: latches the
// control word, shifts each data word's low byte out and writes the reply back.
module module_spi_transfer_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [N-1:0]          addr_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  wr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  hold_ctrl_o,
    output logic                  busy_o,
    input  logic                  miso_i,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic                  cs_o
);

    state_t                state;
    logic [N-1:0]          ptr;
    logic [CNT_W-1:0]      tx_cnt;
    logic [CNT_W-1:0]      n_tx_end;
    logic [CNT_W-1:0]      rx_cnt;
    logic [DATA_WIDTH-1:0] ctrl_q;
    logic                  sh_start;
    logic                  sh_done;
    logic [7:0]            sh_rx;

    assign sh_start    = (state == ST_LOAD);
    assign busy_o      = (state != ST_IDLE);
    assign hold_ctrl_o = busy_o;
    assign wr_o        = (state == ST_STORE) || (state == ST_FINISH);

    always_comb begin
        addr_o = N'(CTRL_ADDR);
        if ((state == ST_LOAD) || (state == ST_SHIFT) ||
            (state == ST_STORE) || (state == ST_NEXT)) begin
            addr_o = ptr;
        end
    end

    always_comb begin
        data_o = '0;
        if (state == ST_STORE) begin
            data_o = DATA_WIDTH'(sh_rx);
        end else if (state == ST_FINISH) begin
            data_o                   = ctrl_q;
            data_o[SEND_BIT]         = 1'b0;
            data_o[NRX_MSB:NRX_LSB]  = rx_cnt;
        end
    end

    module_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (sh_start),
        .tx_byte_i (data_i[7:0]),
        .miso_i    (miso_i),
        .done_o    (sh_done),
        .rx_byte_o (sh_rx),
        .sclk_o    (sclk_o),
        .mosi_o    (mosi_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            tx_cnt   <= '0;
            n_tx_end <= '0;
            rx_cnt   <= '0;
            ctrl_q   <= '0;
            cs_o     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_i[SEND_BIT]) begin
                        ctrl_q   <= data_i;
                        n_tx_end <= data_i[NTX_MSB:NTX_LSB];
                        ptr      <= N'(1);
                        tx_cnt   <= '0;
                        rx_cnt   <= '0;
                        cs_o     <= 1'b0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sh_done) begin
                        state <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    if (rx_cnt != '1) begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                    state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (tx_cnt == n_tx_end) begin
                        cs_o  <= 1'b1;
                        state <= ST_FINISH;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                        // Word 0 is the control word, so the pointer skips it on wrap.
                        ptr    <= (ptr == '1) ? N'(1) : ptr + N'(1);
                        state  <= ST_LOAD;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_spi_transfer_ctrl.sv
// Bench for the SPI transfer engine: register-bank and SPI-slave models around
// the DUT, results compared against a word-level transfer model.
module tb_module_spi_transfer_ctrl;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned CD = 2;
    localparam int unsigned NW = (1 << N) - 1;
    localparam int unsigned FRAME = 16 * CD + 3;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [N-1:0]  addr_o;
    logic [DW-1:0] data_i;
    logic          wr_o;
    logic [DW-1:0] data_o;
    logic          hold_ctrl_o;
    logic          busy_o;
    logic          miso_i;
    logic          sclk_o;
    logic          mosi_o;
    logic          cs_o;

    int checks   = 0;
    int failures = 0;

    module_spi_transfer_ctrl #(
        .N          (N),
        .DATA_WIDTH (DW),
        .CLK_DIV    (CD)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .addr_o      (addr_o),
        .data_i      (data_i),
        .wr_o        (wr_o),
        .data_o      (data_o),
        .hold_ctrl_o (hold_ctrl_o),
        .busy_o      (busy_o),
        .miso_i      (miso_i),
        .sclk_o      (sclk_o),
        .mosi_o      (mosi_o),
        .cs_o        (cs_o)
    );

    always #50 clk_i = ~clk_i;

    // Register bank: engine port has priority; client port is blocked by hold.
    logic [DW-1:0] bank [0:(1<<N)-1] = '{default: '0};
    logic          cl_wr   = 1'b0;
    logic [N-1:0]  cl_addr = '0;
    logic [DW-1:0] cl_data = '0;

    assign data_i = bank[addr_o];

    always @(posedge clk_i) begin
        if (wr_o) bank[addr_o] <= data_o;
        else if (cl_wr && !hold_ctrl_o) bank[cl_addr] <= cl_data;
    end

    // SPI slave: replies MSB first, changes MISO after falling edges.
    logic [7:0] reply_arr [0:511];
    logic [7:0] mosi_cap  [0:511];
    logic [2:0] bit_idx   = '0;
    logic [8:0] frame_idx = '0;
    logic [7:0] mosi_sr   = '0;
    int         frames_total = 0;
    int         rises        = 0;

    assign miso_i = reply_arr[frame_idx][3'd7 - bit_idx];

    always @(posedge sclk_o or negedge sclk_o or posedge cs_o) begin
        if (cs_o) begin
            bit_idx   <= '0;
            frame_idx <= '0;
        end else if (sclk_o) begin
            mosi_sr <= {mosi_sr[6:0], mosi_o};
            rises   <= rises + 1;
        end else if (bit_idx == 3'd7) begin
            mosi_cap[frame_idx] <= mosi_sr;
            frame_idx    <= frame_idx + 9'd1;
            bit_idx      <= '0;
            frames_total <= frames_total + 1;
        end else begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    int cs_low  = 0;
    int busy_c  = 0;
    int wr_c    = 0;
    int wr0_c   = 0;
    int sclk_hi = 0;
    int wr_sclk = 0;

    always @(posedge clk_i) begin
        if (!cs_o)            cs_low  <= cs_low + 1;
        if (busy_o)           busy_c  <= busy_c + 1;
        if (wr_o)             wr_c    <= wr_c + 1;
        if (wr_o && addr_o == '0) wr0_c <= wr0_c + 1;
        if (sclk_o)           sclk_hi <= sclk_hi + 1;
        if (wr_o && sclk_o)   wr_sclk <= wr_sclk + 1;
    end

    logic [DW-1:0] sh_w [1:NW];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic client_write(input logic [N-1:0] a, input logic [DW-1:0] d);
        @(negedge clk_i);
        cl_addr = a;
        cl_data = d;
        cl_wr   = 1'b1;
        @(negedge clk_i);
        cl_wr   = 1'b0;
    endtask

    task automatic preload(input logic [DW-1:0] w1, input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        client_write(N'(1), w1); sh_w[1] = w1;
        client_write(N'(2), w2); sh_w[2] = w2;
        client_write(N'(3), w3); sh_w[3] = w3;
    endtask

    task automatic wait_sclk_high(output bit to);
        to = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (sclk_o) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int n = 0; n < 10 && !busy_o; n++) @(negedge clk_i);
        if (busy_o) begin
            for (int n = 0; n < 20000; n++) begin
                @(negedge clk_i);
                if (!busy_o) begin
                    to = 1'b0;
                    break;
                end
            end
        end
    endtask

    // Word-level model: word k goes to pointer 1 + k mod NW, sends that word's
    // current low byte and is replaced by the zero-extended reply.
    task automatic run_xfer(input logic [DW-1:0] ctrl, input bit do_write, input bit meddle, input string name);
        int            words;
        int            p;
        logic [DW-1:0] m [1:NW];
        logic [7:0]    exp_mosi [0:511];
        logic [DW-1:0] exp_ctrl;
        int s_cs, s_busy, s_wr, s_wr0, s_hi, s_ws, s_rise, s_fr;
        bit to;

        words = int'(ctrl[9:2]) + 1;
        for (int i = 1; i <= int'(NW); i++) m[i] = sh_w[i];
        for (int k = 0; k < words; k++) begin
            p = 1 + (k % int'(NW));
            exp_mosi[k] = m[p][7:0];
            m[p] = {24'h0, reply_arr[k]};
        end
        exp_ctrl        = ctrl;
        exp_ctrl[0]     = 1'b0;
        exp_ctrl[17:10] = (words > 255) ? 8'd255 : 8'(words);

        s_cs = cs_low; s_busy = busy_c; s_wr = wr_c; s_wr0 = wr0_c;
        s_hi = sclk_hi; s_ws = wr_sclk; s_rise = rises; s_fr = frames_total;

        if (do_write) client_write('0, ctrl);
        if (meddle) begin
            wait_sclk_high(to);
            check({name, "_sclk_seen"}, 64'(to), 64'd0);
            check({name, "_hold_mid"}, 64'(hold_ctrl_o), 64'd1);
            client_write('0, 32'h0000_0000);
            client_write(N'(1), 32'hDEAD_BEEF);
        end
        wait_done(to);
        check({name, "_timeout"}, 64'(to), 64'd0);

        check({name, "_ctrl"}, 64'(bank[0]), 64'(exp_ctrl));
        for (int i = 1; i <= int'(NW); i++)
            check($sformatf("%s_word%0d", name, i), 64'(bank[i]), 64'(m[i]));
        for (int k = 0; k < words; k++)
            check($sformatf("%s_mosi%0d", name, k), 64'(mosi_cap[k]), 64'(exp_mosi[k]));
        check({name, "_frames"},  64'(frames_total - s_fr), 64'(words));
        check({name, "_sclk_rise"}, 64'(rises - s_rise), 64'(words * 8));
        check({name, "_sclk_hi"}, 64'(sclk_hi - s_hi), 64'(words * 8 * int'(CD)));
        check({name, "_cs_low"},  64'(cs_low - s_cs), 64'(words * int'(FRAME)));
        check({name, "_busy"},    64'(busy_c - s_busy), 64'(words * int'(FRAME) + 1));
        check({name, "_wr"},      64'(wr_c - s_wr), 64'(words + 1));
        check({name, "_wr_ctrl"}, 64'(wr0_c - s_wr0), 64'd1);
        check({name, "_wr_sclk"}, 64'(wr_sclk - s_ws), 64'd0);
        check({name, "_cs_end"},  64'(cs_o), 64'd1);
        for (int i = 1; i <= int'(NW); i++) sh_w[i] = m[i];
    endtask

    initial begin
        logic [DW-1:0] ctrl;
        int s_rise, s_wr, s_cs;
        bit to;

        for (int i = 0; i < 512; i++) reply_arr[i] = '0;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_cs", 64'(cs_o), 64'd1);
        check("rst_sclk", 64'(sclk_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_addr", 64'(addr_o), 64'd0);
        check("rst_wr", 64'(wr_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_hold", 64'(hold_ctrl_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_mosi", 64'(mosi_o), 64'd0);
        check("rst_cs_rel", 64'(cs_o), 64'd1);

        // Single word 0xA5 out, slave replies 0x3C
        preload(32'h0000_00A5, 32'h0, 32'h0);
        reply_arr[0] = 8'h3C;
        run_xfer(32'h0000_0001, 1'b1, 1'b0, "a5");
        check("a5_word1_abs", 64'(bank[1]), 64'h3C);
        check("a5_ctrl_abs", 64'(bank[0]), 64'h400);
        check("a5_mosi_abs", 64'(mosi_cap[0]), 64'hA5);

        // Three words, slave echoes
        preload(32'h11, 32'h22, 32'h33);
        reply_arr[0] = 8'h11; reply_arr[1] = 8'h22; reply_arr[2] = 8'h33;
        run_xfer(32'h0000_0009, 1'b1, 1'b0, "echo3");
        check("echo3_ctrl_abs", 64'(bank[0]), 64'hC08);

        // Five words on a 3-word bank: pointer wraps 1,2,3,1,2
        preload($urandom, $urandom, $urandom);
        for (int k = 0; k < 5; k++) reply_arr[k] = 8'($urandom_range(0, 255));
        run_xfer(32'h0000_0011, 1'b1, 1'b0, "wrap5");
        check("wrap5_ctrl_abs", 64'(bank[0]), 64'h1410);

        // Client writes during SHIFT are blocked by hold
        preload($urandom, $urandom, $urandom);
        for (int k = 0; k < 2; k++) reply_arr[k] = 8'($urandom_range(0, 255));
        run_xfer(32'h0000_0005, 1'b1, 1'b1, "hold");

        // Random control words (upper fields and all_ss random)
        for (int r = 0; r < 3; r++) begin
            preload($urandom, $urandom, $urandom);
            for (int k = 0; k < 16; k++) reply_arr[k] = 8'($urandom_range(0, 255));
            ctrl = $urandom;
            ctrl[0] = 1'b1;
            ctrl[9:2] = 8'($urandom_range(0, 9));
            run_xfer(ctrl, 1'b1, 1'b0, $sformatf("rand%0d", r));
        end

        // 256 words: receive count saturates at 255
        preload($urandom, $urandom, $urandom);
        for (int k = 0; k < 256; k++) reply_arr[k] = 8'($urandom_range(0, 255));
        run_xfer(32'h0000_03FD, 1'b1, 1'b0, "max256");

        // send=0 with other fields set: engine stays idle
        s_rise = rises; s_wr = wr_c; s_cs = cs_low;
        client_write('0, 32'h0003_FFFE);
        repeat (100) @(negedge clk_i);
        check("idle_sclk", 64'(rises - s_rise), 64'd0);
        check("idle_wr", 64'(wr_c - s_wr), 64'd0);
        check("idle_cs", 64'(cs_low - s_cs), 64'd0);
        check("idle_busy", 64'(busy_o), 64'd0);
        check("idle_ctrl", 64'(bank[0]), 64'h0003_FFFE);

        // Asynchronous reset mid-SHIFT, then the still-pending send restarts cleanly
        preload($urandom, $urandom, $urandom);
        for (int k = 0; k < 2; k++) reply_arr[k] = 8'($urandom_range(0, 255));
        ctrl = 32'h0000_0005;
        client_write('0, ctrl);
        wait_sclk_high(to);
        check("rstmid_sclk_seen", 64'(to), 64'd0);
        #10 rst_i = 1'b1;
        #1;
        check("rstmid_cs", 64'(cs_o), 64'd1);
        check("rstmid_sclk", 64'(sclk_o), 64'd0);
        check("rstmid_hold", 64'(hold_ctrl_o), 64'd0);
        check("rstmid_wr", 64'(wr_o), 64'd0);
        check("rstmid_busy", 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk_i);
        check("rstmid_bank0", 64'(bank[0]), 64'(ctrl));
        for (int i = 1; i <= int'(NW); i++)
            check($sformatf("rstmid_bank%0d", i), 64'(bank[i]), 64'(sh_w[i]));
        rst_i = 1'b0;
        check("rstmid_idle", 64'(busy_o), 64'd0);
        run_xfer(ctrl, 1'b0, 1'b0, "rst_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
